// File: rtl/cpu_pkg.sv
// Shared branch-prediction types: 2-bit direction counter encoding, saturating update, lookup view.
// Used by branch_predictor (optional BPRED_STATS_EN counters) and bpred_ctr_table.
package cpu_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t SNT = 2'd0;
   localparam ctr_t WNT = 2'd1;
   localparam ctr_t WT  = 2'd2;
   localparam ctr_t ST  = 2'd3;

   // Tag and target widths are parameter-dependent, so they live in parallel
   // arrays in branch_predictor; this struct is the decoded view of one slot.
   typedef struct packed {
      logic valid;
      logic hit;
      ctr_t ctr;
   } bpred_entry;

   function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
      ctr_t nxt;
      if (taken) nxt = (ctr == ST)  ? ST  : ctr + 2'd1;
      else       nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/bpred_ctr_table.sv
// NENTRY x 2-bit direction counter array: two combinational read ports (fetch lookup,
// resolve-side read-modify-write) and one synchronous write port; resets every counter to WNT.
module bpred_ctr_table
   import cpu_pkg::*;
#(
   parameter int NENTRY = 16,
   parameter int IDX_W  = $clog2(NENTRY)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd0_idx,
   output logic [1:0]       rd0_ctr,
   input  logic [IDX_W-1:0] rd1_idx,
   output logic [1:0]       rd1_ctr,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [1:0]       wr_ctr
);

   ctr_t ctr_q [NENTRY];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NENTRY; i++) ctr_q[i] <= WNT;
      end else if (wr_en) begin
         ctr_q[wr_idx] <= wr_ctr;
      end
   end

   assign rd0_ctr = ctr_q[rd0_idx];
   assign rd1_ctr = ctr_q[rd1_idx];

endmodule

// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit direction counters: combinational lookup for IF, update from MEM.
// Defining BPRED_STATS_EN adds stat_updates / stat_mispredicts event counters.
module branch_predictor
   import cpu_pkg::*;
#(
   parameter int NENTRY = 16,
   parameter int TAG_W  = 8,
   parameter int XLEN   = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   // upd_valid is a one-cycle qualifier with no back-pressure: every valid update is consumed.
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_is_jump,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_predicted,
   output logic            mispredict
`ifdef BPRED_STATS_EN
   ,
   output logic [31:0]     stat_updates,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int IDX_W = $clog2(NENTRY);

   logic [NENTRY-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]  tag_q    [NENTRY];
   logic [XLEN-1:0]   target_q [NENTRY];

   logic [IDX_W-1:0] if_idx, up_idx;
   logic [TAG_W-1:0] if_tag, up_tag;
   logic [1:0]       if_ctr, up_ctr;
   bpred_entry       if_e, up_e;

   logic accept;
   logic ctr_we;
   ctr_t ctr_wdata;
   logic ent_we;
   logic unused_pc_bits;

   assign if_idx = if_pc[IDX_W+1:2];
   assign if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign up_idx = upd_pc[IDX_W+1:2];
   assign up_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign unused_pc_bits = ^{if_pc, upd_pc};

   bpred_ctr_table #(.NENTRY(NENTRY), .IDX_W(IDX_W)) u_ctr_table (
      .clk     (clk),
      .reset   (reset),
      .rd0_idx (if_idx),
      .rd0_ctr (if_ctr),
      .rd1_idx (up_idx),
      .rd1_ctr (up_ctr),
      .wr_en   (ctr_we),
      .wr_idx  (up_idx),
      .wr_ctr  (ctr_wdata)
   );

   always_comb begin
      if_e.valid = valid_q[if_idx];
      if_e.hit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      if_e.ctr   = if_ctr;
      up_e.valid = valid_q[up_idx];
      up_e.hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
      up_e.ctr   = up_ctr;
   end

   // Lookup reads pre-update state; a same-cycle update becomes visible next cycle.
   assign pred_taken  = if_e.hit & if_e.ctr[1];
   assign pred_target = if_e.hit ? target_q[if_idx] : '0;

   assign accept     = upd_valid & ~reset;
   assign mispredict = accept & (upd_taken != upd_predicted);

   always_comb begin
      ctr_we    = 1'b0;
      ctr_wdata = up_e.ctr;
      ent_we    = 1'b0;
      valid_d   = valid_q;
      if (accept) begin
         if (up_e.hit) begin
            ctr_we = 1'b1;
            if (upd_is_jump) begin
               ctr_wdata = ST;
               ent_we    = 1'b1;
            end else begin
               ctr_wdata = sat_update(up_e.ctr, upd_taken);
               ent_we    = upd_taken;
            end
         end else if (upd_taken) begin
            // Allocate on a taken miss, evicting whatever occupied the slot.
            ctr_we          = 1'b1;
            ent_we          = 1'b1;
            ctr_wdata       = upd_is_jump ? ST : WT;
            valid_d[up_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) valid_q <= '0;
      else       valid_q <= valid_d;
   end

   always_ff @(posedge clk) begin
      if (ent_we) begin
         tag_q[up_idx]    <= up_tag;
         target_q[up_idx] <= upd_target;
      end
   end

`ifdef BPRED_STATS_EN
   logic [31:0] stat_upd_q, stat_mis_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_upd_q <= '0;
         stat_mis_q <= '0;
      end else begin
         if (accept)     stat_upd_q <= stat_upd_q + 32'd1;
         if (mispredict) stat_mis_q <= stat_mis_q + 32'd1;
      end
   end

   assign stat_updates     = stat_upd_q;
   assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer with 2-bit saturating direction counters for the five-stage pipeline.
- Used in IF: it predicts taken/target for the current PC so fetch can redirect early. This reduces the 3-instruction flush on taken branches and jumps.
- Updated from MEM with the resolved outcome, at the point where branch and jump resolve today.

Parameters:
- NENTRY, 16, number of BTB entries; power of 2, minimum 2; IDX_W = $clog2(NENTRY).
- TAG_W, 8, tag bits stored per entry; IDX_W+TAG_W+2 <= 32.
- XLEN, 32, PC and target width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- if_pc  in  XLEN  PC of instruction being fetched.
- pred_taken  out  1  predict redirect for if_pc.
- pred_target  out  XLEN  predicted next PC; valid only when pred_taken=1.
- upd_valid  in  1  resolved branch/jump present in MEM this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_is_jump  in  1  resolved instruction is an unconditional jump.
- upd_taken  in  1  actual outcome (1 for jumps).
- upd_target  in  XLEN  actual taken target (baddr/jaddr).
- upd_predicted  in  1  pred_taken value originally given for upd_pc (carried down the pipe).
- mispredict  out  1  combinational: upd_valid & (upd_taken != upd_predicted); MEM uses it to flush.

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry fields: valid, tag[TAG_W], target[XLEN], ctr[2]. Counter states:
  - SNT=0, WNT=1, WT=2, ST=3.
- Lookup is combinational, same cycle as if_pc.
  - hit = valid & tag match at index.
  - pred_taken = hit & ctr[1].
  - pred_target = hit ? target : 0.
- Reset:
  - All valid bits cleared on the reset cycle; ctr cleared to WNT; target and tag are don't-care.
  - pred_taken=0 and pred_target=0 from the first cycle after reset until an allocation occurs.
  - mispredict is forced 0 while reset=1.
  - An update presented while reset=1 is ignored.
  - Reset mid-operation discards all learned state.
- Update (posedge, upd_valid=1, reset=0), by case:
  - Hit, jump: ctr=ST, target=upd_target.
  - Hit, conditional, taken: ctr=min(ctr+1,ST), target=upd_target.
  - Hit, conditional, not taken: ctr=max(ctr-1,SNT); target unchanged.
  - Miss (invalid or tag mismatch), taken: allocate, replacing any existing entry. Set valid=1, tag, target, and ctr=ST for a jump or WT for a conditional branch.
  - Miss, not taken: no change; no allocation.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents. The new value is visible from the next cycle; there is no bypass.
- Counters saturate and never wrap.
- Target is stored at full XLEN, with no truncation.
- Storage is a register array; synthesis inference as distributed RAM is acceptable if combinational read is preserved.

Optional Feature:
- Macro: BPRED_STATS_EN.
- When defined, adds outputs stat_updates[31:0] and stat_mispredicts[31:0].
- Both clear on reset. They increment by 1 on each accepted update and each mispredict respectively, and wrap modulo 2^32.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg:
  - Counter state constants SNT/WNT/WT/ST and the 2-bit ctr typedef.
  - Function sat_update(ctr, taken) returning the next counter value.
  - bpred_entry struct typedef.
- One natural sub-module, bpred_ctr_table: NENTRY x 2-bit counter array with combinational read, single write port, and reset to WNT.
- Tag/target storage and control stay in branch_predictor.

Test Plan:
1. Reset with any if_pc: pred_taken=0 and pred_target=0 on every PC; an update issued during reset (upd_pc=0x40, taken) is ignored, so a lookup of 0x40 afterwards gives pred_taken=0.
2. Update upd_pc=0x40, conditional, taken, target=0x80 → next cycle if_pc=0x40 gives pred_taken=1, pred_target=0x80 (ctr=WT). Then one not-taken update → pred_taken=0 (WNT); two taken updates → ST; three more taken → remains ST.
3. Jump upd_pc=0x100, target=0x200 → pred_taken=1, pred_target=0x200. A not-taken conditional miss at 0x104 allocates nothing.
4. Aliasing, NENTRY=16: allocate 0x40 (target 0x80), then taken 0x440 (same index, different tag, target 0x500). Lookup 0x40 gives pred_taken=0; lookup 0x440 gives pred_target=0x500.
5. Same-cycle lookup and update of 0x40: that cycle shows the old prediction; the next cycle shows the new one. Also check mispredict=1 when upd_predicted=0 and upd_taken=1.
6. With BPRED_STATS_EN: 5 updates including 2 mispredicts → stat_updates=5, stat_mispredicts=2; reset → both 0.
